// File: rtl/wr_ptr_ctrl_if.sv
// Write-side FIFO pointer bundle: write request and read-pointer Gray code in, RAM
// write controls, pointers and status flags out.
interface wr_ptr_ctrl_if #(
    parameter int unsigned PTR_WIDTH = 5
);
    logic                 wr_en_i;
    logic [PTR_WIDTH:0]   rp2wp_gray_i;
    logic                 wr_fire_o;
    logic [PTR_WIDTH-1:0] waddr_o;
    logic [PTR_WIDTH:0]   wptr_bin_o;
    logic [PTR_WIDTH:0]   wptr_gray_o;
    logic                 full_o;
    logic                 afull_o;
    logic [PTR_WIDTH:0]   wr_cnt_o;
    logic                 overflow_o;

    modport master (
        output wr_en_i, rp2wp_gray_i,
        input  wr_fire_o, waddr_o, wptr_bin_o, wptr_gray_o, full_o, afull_o, wr_cnt_o,
               overflow_o
    );

    modport slave (
        input  wr_en_i, rp2wp_gray_i,
        output wr_fire_o, waddr_o, wptr_bin_o, wptr_gray_o, full_o, afull_o, wr_cnt_o,
               overflow_o
    );
endinterface

// File: rtl/wr_ptr_ctrl.sv
// Async FIFO write-domain pointer controller: binary/Gray write pointers, two-flop read
// pointer synchronizer, and pessimistic full / almost-full / occupancy / overflow status.
module wr_ptr_ctrl #(
    parameter int unsigned PTR_WIDTH = 5,
    parameter int unsigned AFULL_TH  = (2 ** PTR_WIDTH) - 4
) (
    input logic          wr_clk_i,
    input logic          rstn_i,
    wr_ptr_ctrl_if.slave bus
);
    localparam int unsigned P = PTR_WIDTH;
    localparam logic [P:0] AfullTh = (P + 1)'(AFULL_TH);

    logic [P:0] wbin_q, wbin_d;
    logic [P:0] wgray_q, wgray_d;
    logic [P:0] rq1_q, rq2_q;
    logic [P:0] rbin;
    logic [P:0] cnt_q, cnt_d;
    logic       full_q, full_d;
    logic       afull_q, afull_d;
    logic       ovf_q, ovf_d;
    logic       fire;

    always_comb begin
        // Bit j of the binary value is the XOR of Gray bits j..MSB.
        rbin = '0;
        for (int unsigned j = 0; j <= P; j++) begin
            rbin[j] = ^(rq2_q >> j);
        end

        fire    = bus.wr_en_i & ~full_q;
        wbin_d  = wbin_q + {{P{1'b0}}, fire};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        full_d  = (wgray_d == {~rq2_q[P:P-1], rq2_q[P-2:0]});
        cnt_d   = wbin_d - rbin;
        afull_d = (cnt_d >= AfullTh);
        ovf_d   = bus.wr_en_i & full_q;
    end

    always_ff @(posedge wr_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= bus.rp2wp_gray_i;
            rq2_q   <= rq1_q;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.wr_fire_o   = fire;
    assign bus.waddr_o     = wbin_q[P-1:0];
    assign bus.wptr_bin_o  = wbin_q;
    assign bus.wptr_gray_o = wgray_q;
    assign bus.full_o      = full_q;
    assign bus.afull_o     = afull_q;
    assign bus.wr_cnt_o    = cnt_q;
    assign bus.overflow_o  = ovf_q;
endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Bench for wr_ptr_ctrl: fill/overflow vector table, hand-written drain, wrap and reset
// sequences, and random traffic checked against an occupancy-arithmetic model.
module tb_wr_ptr_ctrl;
    localparam int PW    = 5;
    localparam int DEPTH = 32;
    localparam int MOD   = 64;
    localparam int AF    = DEPTH - 4;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    // Model: write count, read pointer as seen two edges late, and derived flags.
    int m_wbin, s1, s2, m_cnt;
    bit m_full, m_afull, m_ovf;
    int rd_cur;

    typedef struct {
        bit wr;
        int rd;
        bit fire;
        int wbin;
        int gray;
        int cnt;
        bit full;
        bit afull;
        bit ovf;
    } vec_t;
    vec_t tbl[36];

    wr_ptr_ctrl_if #(.PTR_WIDTH(PW)) bus ();

    wr_ptr_ctrl #(
        .PTR_WIDTH(PW),
        .AFULL_TH (AF)
    ) dut (
        .wr_clk_i(clk),
        .rstn_i  (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wbin = 0; s1 = 0; s2 = 0; m_cnt = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
        rd_cur = 0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_wbin"}, bus.wptr_bin_o, 0);
        chk({nm, "_gray"}, bus.wptr_gray_o, 0);
        chk({nm, "_waddr"}, bus.waddr_o, 0);
        chk({nm, "_cnt"}, bus.wr_cnt_o, 0);
        chk({nm, "_full"}, bus.full_o, 0);
        chk({nm, "_afull"}, bus.afull_o, 0);
        chk({nm, "_ovf"}, bus.overflow_o, 0);
    endtask

    // Starts and ends on a falling edge.
    task automatic tick(input bit wr, input int rd, output bit fire_seen);
        bit fire;
        bus.wr_en_i      = wr;
        bus.rp2wp_gray_i = 6'(rd ^ (rd >> 1));
        #1;
        fire_seen = bus.wr_fire_o;
        chk("wr_fire", fire_seen, int'(wr && !m_full));
        @(posedge clk);
        fire   = wr && !m_full;
        m_ovf  = wr && m_full;
        m_wbin = (m_wbin + int'(fire)) % MOD;
        m_cnt  = (m_wbin - s2 + MOD) % MOD;
        m_full = (m_cnt == DEPTH);
        m_afull = (m_cnt >= AF);
        s2 = s1;
        s1 = rd;
        #1;
        chk("wbin", bus.wptr_bin_o, m_wbin);
        chk("gray", bus.wptr_gray_o, m_wbin ^ (m_wbin >> 1));
        chk("waddr", bus.waddr_o, m_wbin % DEPTH);
        chk("cnt", bus.wr_cnt_o, m_cnt);
        chk("full", bus.full_o, int'(m_full));
        chk("afull", bus.afull_o, int'(m_afull));
        chk("ovf", bus.overflow_o, int'(m_ovf));
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            bus.wr_en_i      = 1'($urandom_range(0, 1));
            bus.rp2wp_gray_i = 6'($urandom);
            @(negedge clk);
            check_zero("rst");
        end
        bus.wr_en_i      = 1'b0;
        bus.rp2wp_gray_i = '0;
        rstn = 1'b1;
    endtask

    initial begin
        bit f;

        for (int i = 0; i < 32; i++) begin
            tbl[i] = '{wr: 1'b1, rd: 0, fire: 1'b1, wbin: i + 1,
                       gray: (i + 1) ^ ((i + 1) >> 1), cnt: i + 1,
                       full: (i == 31), afull: (i + 1 >= AF), ovf: 1'b0};
        end
        for (int i = 32; i < 35; i++) begin
            tbl[i] = '{wr: 1'b1, rd: 0, fire: 1'b0, wbin: 32, gray: 6'b110000,
                       cnt: 32, full: 1'b1, afull: 1'b1, ovf: 1'b1};
        end
        tbl[35] = '{wr: 1'b0, rd: 0, fire: 1'b0, wbin: 32, gray: 6'b110000,
                    cnt: 32, full: 1'b1, afull: 1'b1, ovf: 1'b0};

        bus.wr_en_i      = 1'b0;
        bus.rp2wp_gray_i = '0;
        rstn = 1'b1;
        @(negedge clk);

        // Reset, then a single write.
        apply_reset();
        tick(1'b1, 0, f);
        chk("first_wbin", bus.wptr_bin_o, 1);
        chk("first_gray", bus.wptr_gray_o, 6'b000001);
        chk("first_cnt", bus.wr_cnt_o, 1);

        // Fill and overflow from the vector table.
        apply_reset();
        for (int i = 0; i < 36; i++) begin
            tick(tbl[i].wr, tbl[i].rd, f);
            chk($sformatf("tbl%0d_fire", i), f, tbl[i].fire);
            chk($sformatf("tbl%0d_wbin", i), bus.wptr_bin_o, tbl[i].wbin);
            chk($sformatf("tbl%0d_gray", i), bus.wptr_gray_o, tbl[i].gray);
            chk($sformatf("tbl%0d_cnt", i), bus.wr_cnt_o, tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), bus.full_o, tbl[i].full);
            chk($sformatf("tbl%0d_afull", i), bus.afull_o, tbl[i].afull);
            chk($sformatf("tbl%0d_ovf", i), bus.overflow_o, tbl[i].ovf);
        end

        // Drain visibility: read pointer 1 shows up two edges after capture.
        tick(1'b0, 1, f);
        chk("drain_n_full", bus.full_o, 1);
        chk("drain_n_cnt", bus.wr_cnt_o, 32);
        tick(1'b0, 1, f);
        chk("drain_n1_full", bus.full_o, 1);
        chk("drain_n1_cnt", bus.wr_cnt_o, 32);
        tick(1'b0, 1, f);
        chk("drain_n2_full", bus.full_o, 0);
        chk("drain_n2_cnt", bus.wr_cnt_o, 31);

        // Wrap: 63 write/read pairs, then one more write rolls 63 -> 0.
        apply_reset();
        for (int i = 0; i < 63; i++) tick(1'b1, i, f);
        chk("wrap_pre_wbin", bus.wptr_bin_o, 63);
        tick(1'b1, 63, f);
        rd_cur = 63;
        chk("wrap_wbin", bus.wptr_bin_o, 0);
        chk("wrap_gray", bus.wptr_gray_o, 0);
        chk("wrap_waddr", bus.waddr_o, 0);
        chk("wrap_cnt", bus.wr_cnt_o, 3);

        // Random traffic: write-heavy, then read-heavy.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 300; c++) begin
                int wprob = (ph == 0) ? 3 : 1;
                int rprob = (ph == 0) ? 1 : 3;
                if (((m_wbin - rd_cur + MOD) % MOD) > 0 && $urandom_range(0, 3) < rprob)
                    rd_cur = (rd_cur + 1) % MOD;
                tick(1'($urandom_range(0, 3) < wprob), rd_cur, f);
            end
        end

        // Asynchronous reset mid-fill.
        apply_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, 0, f);
        chk("mid_pre_wbin", bus.wptr_bin_o, 10);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("mid");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        chk("mid_waddr", bus.waddr_o, 0);
        tick(1'b1, 0, f);
        chk("mid_fire", f, 1);
        chk("mid_wbin", bus.wptr_bin_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wr_ptr_ctrl.md
# wr_ptr_ctrl

Write-side pointer and status controller for the async FIFO, running entirely in the write clock domain. It advances the binary and Gray write pointers on accepted writes and synchronizes the read pointer's Gray code from the read domain through two flops. From these it produces the RAM write address and enable, full / almost-full flags, the write-side occupancy count and an overflow pulse. It is the write-domain counterpart of the read-side count logic; its `wptr_gray_o` feeds the read domain's synchronizer.

## Interface
- `PTR_WIDTH`, 5, address width; FIFO depth = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits; legal range ≥ 2.
- `AFULL_TH`, 2^PTR_WIDTH−4, almost-full threshold in entries; legal range 1..2^PTR_WIDTH.
- `wr_clk_i`  in  1  write clock; the block's only clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `wr_en_i`  in  1  write request for the current cycle.
- `rp2wp_gray_i`  in  PTR_WIDTH+1  read pointer in Gray code, launched from the read domain, unsynchronized.
- `wr_fire_o`  out  1  combinational, `wr_en_i & ~full_o`; RAM write enable.
- `waddr_o`  out  PTR_WIDTH  RAM write address, `wptr_bin_o[PTR_WIDTH-1:0]`.
- `wptr_bin_o`  out  PTR_WIDTH+1  registered binary write pointer.
- `wptr_gray_o`  out  PTR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `full_o`  out  1  registered full flag.
- `afull_o`  out  1  registered almost-full flag.
- `wr_cnt_o`  out  PTR_WIDTH+1  registered occupancy as seen from the write side, 0..2^PTR_WIDTH.
- `overflow_o`  out  1  registered one-cycle pulse, raised for a write attempted while full.

## Operation
- Reset (`rstn_i` = 0, asynchronous):
  - `wptr_bin`, `wptr_gray`, `rq1`, `rq2`, `wr_cnt_o` = 0.
  - `full_o`, `afull_o`, `overflow_o` = 0.
- Synchronizer: `rq1 <= rp2wp_gray_i`; `rq2 <= rq1`. No other logic touches `rq1`.
- Read pointer Gray-to-binary conversion, applied to `rq2`:
  - `rbin[MSB] = rq2[MSB]`.
  - `rbin[j] = rq2[j] ^ rbin[j+1]`.
- Next-state values:
  - `wbin_nx = wptr_bin + wr_fire_o`, modulo 2^(PTR_WIDTH+1).
  - `wgray_nx = wbin_nx ^ (wbin_nx >> 1)`.
- Register updates on each `wr_clk_i` edge:
  - `wptr_bin <= wbin_nx`; `wptr_gray <= wgray_nx`.
  - `full_o <= (wgray_nx == {~rq2[P:P-1], rq2[P-2:0]})`, where P = PTR_WIDTH.
  - `wr_cnt_o <= wbin_nx − rbin`, PTR_WIDTH+1-bit modular subtraction.
  - `afull_o <= ((wbin_nx − rbin) >= AFULL_TH)`.
  - `overflow_o <= wr_en_i & full_o`.
- A write while full is dropped: `wr_fire_o` = 0, the pointer holds, and `overflow_o` pulses on the next cycle. Sustained attempts produce a pulse every cycle.
- Wrap-around:
  - The binary pointer rolls over from 2^(P+1)−1 to 0.
  - Counts and flags stay correct across the wrap because the subtraction is modular.
- Flags are pessimistic: the read pointer is seen late, so `full_o`, `afull_o` and `wr_cnt_o` may over-report but never under-report.

## Timing
- Write accepted at edge M (`wr_fire_o` = 1 before M): `wptr_*`, `full_o`, `afull_o` and `wr_cnt_o` all reflect it after edge M, i.e. zero extra latency.
- Read-pointer change: `rp2wp_gray_i` changes before edge N → captured in `rq1` at N, in `rq2` at N+1 → visible on `full_o` / `afull_o` / `wr_cnt_o` after edge N+2.
- Simultaneous write and read-pointer change in the same cycle: both are applied; the count equals the new write pointer minus the synchronized read pointer.
- `wr_fire_o` depends combinationally on `wr_en_i` and the registered `full_o`. There is no combinational path from `rp2wp_gray_i` to any output.
- Reset mid-operation: all state clears immediately and asynchronously; the first write after release of `rstn_i` goes to address 0.

## Test plan
- Reset: hold `rstn_i` = 0 with random inputs → all outputs 0, `waddr_o` = 0; release, then one write → `wptr_bin_o` = 1, `wptr_gray_o` = 6'b000001, `wr_cnt_o` = 1.
- Fill (PTR_WIDTH = 5, `rp2wp_gray_i` = 0): 32 back-to-back writes:
  - `afull_o` rises after the 28th write.
  - `full_o` rises after the 32nd write, with `wptr_gray_o` = 6'b110000 and `wr_cnt_o` = 32.
- Overflow: with the FIFO full, assert `wr_en_i` for 3 cycles → `wr_fire_o` = 0, pointer holds at 32, `overflow_o` high for 3 cycles starting one cycle late.
- Drain visibility: with the FIFO full, set `rp2wp_gray_i` = 6'b000001 before edge N:
  - `full_o` = 0 and `wr_cnt_o` = 31 after edge N+2.
  - Both unchanged after edges N and N+1.
- Wrap: preload via 63 write/read pairs, then write once more → `wptr_bin_o` 63→0, `wptr_gray_o` = 0, `waddr_o` = 0; `wr_cnt_o` correct throughout.
- Reset mid-fill: assert `rstn_i` asynchronously between edges after 10 writes → outputs 0 immediately; after release the next write uses `waddr_o` = 0.
